// File: rtl/dpll_pkg.sv
// Types and limits shared by the DPLL phase detector and loop filter.
`include "config.sv"
package dpll_pkg;
   localparam int N_BIT_CFG = `N_BIT;

   // Largest phase error magnitude the PFD reports on a timeout.
   localparam int SAT_LIM = 2**`N_BIT - 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ERR  = 2'd1,
      INT  = 2'd2,
      OUT  = 2'd3
   } filt_state_t;
endpackage

// File: rtl/config.sv
// Shared DPLL build configuration: datapath width of the PFD counters and DCO word.
`ifndef DPLL_CONFIG_SV
`define DPLL_CONFIG_SV
`define N_BIT 8
`endif

// File: rtl/sat_add.sv
// Signed adder saturating symmetrically to +/-(2**(W-1)-1).
module sat_add #(
   parameter int W = 16
) (
   input  logic signed [W-1:0] i_a,
   input  logic signed [W-1:0] i_b,
   output logic signed [W-1:0] o_sum
);
   localparam logic signed [W:0] LIM_P = {2'b00, {(W-1){1'b1}}};
   localparam logic signed [W:0] LIM_N = -LIM_P;

   logic signed [W:0] w_full;

   function automatic logic signed [W-1:0] sat(input logic signed [W:0] v);
      if (v > LIM_P)      return LIM_P[W-1:0];
      else if (v < LIM_N) return LIM_N[W-1:0];
      else                return v[W-1:0];
   endfunction

   assign w_full = {i_a[W-1], i_a} + {i_b[W-1], i_b};
   assign o_sum  = sat(w_full);
endmodule

// File: rtl/loop_filter.sv
// DPLL proportional-integral loop filter: turns each PFD phase measurement
// into a registered DCO control word and tracks lock.
`include "config.sv"
module loop_filter
   import dpll_pkg::*;
#(
   parameter int KP_SHIFT   = 1,
   parameter int KI_SHIFT   = 4,
   parameter int ACC_W      = `N_BIT + 8,
   parameter int CTRL_INIT  = 2**(`N_BIT-1),
   parameter int LOCK_TOL   = 2,
   parameter int LOCK_COUNT = 4
) (
   input  logic              Clock,
   input  logic              nReset,
   input  logic              ready,
   input  logic              timeout,
   input  logic              first_second,
   input  logic [`N_BIT-1:0] diff_1,
   input  logic [`N_BIT-1:0] diff_2,
   output logic [`N_BIT-1:0] ctrl,
   output logic              valid,
   output logic              locked
);
   localparam int NB    = `N_BIT;
   localparam int EW    = NB + 1;
   localparam int SW    = ACC_W + 2;
   localparam int CNT_W = $clog2(LOCK_COUNT + 1);

   localparam logic signed [EW-1:0] E_POS    = EW'(SAT_LIM);
   localparam logic signed [EW-1:0] E_NEG    = -E_POS;
   localparam logic signed [SW-1:0] SUM_INIT = SW'(CTRL_INIT);
   localparam logic signed [SW-1:0] SUM_MAX  = SW'(2**NB - 1);
   localparam logic [EW-1:0]        TOL_E    = EW'(LOCK_TOL);
   localparam logic [CNT_W-1:0]     CNT_MAX  = CNT_W'(LOCK_COUNT);

   filt_state_t              r_state;
   logic                     r_ready_q;
   logic                     r_timeout_q;
   logic signed [EW-1:0]     r_err;
   logic                     r_is_to;
   logic signed [ACC_W-1:0]  r_integ;
   logic signed [SW-1:0]     r_sum;
   logic [NB-1:0]            r_ctrl;
   logic                     r_valid;
   logic                     r_locked;
   logic [CNT_W-1:0]         r_cnt;

   logic                     w_rdy_edge;
   logic                     w_to_edge;
   logic                     w_trig;
   logic signed [EW-1:0]     w_new_e;
   logic signed [ACC_W-1:0]  w_err_ext;
   logic signed [ACC_W-1:0]  w_integ_nxt;
   logic signed [SW-1:0]     w_sum;
   logic [EW-1:0]            w_abs_e;
   logic                     w_in_tol;
   logic [CNT_W-1:0]         w_cnt_nxt;

   function automatic logic [NB-1:0] clamp_ctrl(input logic signed [SW-1:0] s);
      if (s[SW-1])         return '0;
      else if (s > SUM_MAX) return '1;
      else                 return s[NB-1:0];
   endfunction

   assign w_rdy_edge = ready & ~r_ready_q;
   assign w_to_edge  = timeout & ~r_timeout_q;
   assign w_trig     = w_rdy_edge | w_to_edge;

   // Timeout outranks a simultaneous measurement.
   assign w_new_e = w_to_edge ? (first_second ? E_NEG : E_POS)
                              : $signed({1'b0, diff_1}) - $signed({1'b0, diff_2});

   assign w_err_ext = {{(ACC_W-EW){r_err[EW-1]}}, r_err};

   sat_add #(.W(ACC_W)) u_integ_add (
      .i_a   (r_integ),
      .i_b   (w_err_ext),
      .o_sum (w_integ_nxt)
   );

   assign w_sum     = SUM_INIT + SW'(r_err >>> KP_SHIFT) + SW'(r_integ >>> KI_SHIFT);
   assign w_abs_e   = r_err[EW-1] ? -r_err : r_err;
   assign w_in_tol  = (w_abs_e <= TOL_E);
   assign w_cnt_nxt = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 1'b1;

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_state     <= IDLE;
         r_ready_q   <= 1'b0;
         r_timeout_q <= 1'b0;
         r_integ     <= '0;
         r_ctrl      <= NB'(CTRL_INIT);
         r_valid     <= 1'b0;
         r_locked    <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_ready_q   <= ready;
         r_timeout_q <= timeout;
         r_valid     <= 1'b0;
         case (r_state)
            IDLE: if (w_trig) r_state <= ERR;
            ERR: begin
               r_integ <= w_integ_nxt;
               r_state <= INT;
            end
            INT: r_state <= OUT;
            OUT: begin
               r_ctrl  <= clamp_ctrl(r_sum);
               r_valid <= 1'b1;
               if (r_is_to || !w_in_tol) begin
                  r_cnt    <= '0;
                  r_locked <= 1'b0;
               end else begin
                  r_cnt    <= w_cnt_nxt;
                  r_locked <= (w_cnt_nxt == CNT_MAX);
               end
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Datapath holding registers carry no reset; they are always written before use.
   always_ff @(posedge Clock) begin
      if (r_state == IDLE && w_trig) begin
         r_err   <= w_new_e;
         r_is_to <= w_to_edge;
      end
      if (r_state == INT) r_sum <= w_sum;
   end

   assign ctrl   = r_ctrl;
   assign valid  = r_valid;
   assign locked = r_locked;
endmodule

// File: tb/tb_loop_filter.sv
// Self-checking bench for loop_filter: directed scenarios plus randomized events
// compared against an arithmetic model of the PI filter and lock rules.
module tb_loop_filter;
   import dpll_pkg::*;

   localparam int NB      = N_BIT_CFG;
   localparam int C_INIT  = 2**(NB-1);
   localparam int C_MAX   = 2**NB - 1;
   localparam int ACC_LIM = 2**(NB+7) - 1;

   logic          Clock = 1'b0;
   logic          nReset = 1'b1;
   logic          ready = 1'b0;
   logic          timeout = 1'b0;
   logic          first_second = 1'b0;
   logic [NB-1:0] diff_1 = '0;
   logic [NB-1:0] diff_2 = '0;
   logic [NB-1:0] ctrl;
   logic          valid;
   logic          locked;

   int checks = 0;
   int errors = 0;

   int m_integ;
   int m_cnt;
   int m_ctrl;
   bit m_locked;

   loop_filter dut (
      .Clock        (Clock),
      .nReset       (nReset),
      .ready        (ready),
      .timeout      (timeout),
      .first_second (first_second),
      .diff_1       (diff_1),
      .diff_2       (diff_2),
      .ctrl         (ctrl),
      .valid        (valid),
      .locked       (locked)
   );

   always #5 Clock = ~Clock;

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      assert (act === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   function automatic int floor_div(input int v, input int d);
      int q;
      q = v / d;
      if ((v % d != 0) && ((v < 0) != (d < 0))) q = q - 1;
      return q;
   endfunction

   task automatic model_reset();
      m_integ  = 0;
      m_cnt    = 0;
      m_ctrl   = C_INIT;
      m_locked = 0;
   endtask

   // kind: 0 = ready only, 1 = timeout only, 2 = both together
   task automatic model_event(input int kind, input bit fs, input int d1, input int d2);
      int e;
      int sum;
      int ae;
      if (kind != 0) e = fs ? -SAT_LIM : SAT_LIM;
      else           e = d1 - d2;
      m_integ = m_integ + e;
      if (m_integ > ACC_LIM)  m_integ = ACC_LIM;
      if (m_integ < -ACC_LIM) m_integ = -ACC_LIM;
      sum = C_INIT + floor_div(e, 2) + floor_div(m_integ, 16);
      m_ctrl = (sum < 0) ? 0 : (sum > C_MAX) ? C_MAX : sum;
      ae = (e < 0) ? -e : e;
      if (kind != 0 || ae > 2) begin
         m_cnt    = 0;
         m_locked = 0;
      end else begin
         m_cnt    = (m_cnt + 1 > 4) ? 4 : m_cnt + 1;
         m_locked = (m_cnt == 4);
      end
   endtask

   task automatic do_reset(input bit release_it);
      nReset = 1'b0;
      #1;
      check("rst_ctrl", ctrl, C_INIT);
      check("rst_valid", valid, 0);
      check("rst_locked", locked, 0);
      model_reset();
      tick();
      tick();
      if (release_it) nReset = 1'b1;
   endtask

   task automatic run_event(input int kind, input bit fs, input int d1, input int d2,
                            input bit rel_reset, input string tag);
      int            nval;
      int            pos;
      logic [NB-1:0] c_at;
      logic [NB-1:0] c_pre;
      logic          l_at;
      bit            held;
      nval  = 0;
      pos   = -1;
      c_at  = '0;
      l_at  = 1'b0;
      held  = 1;
      c_pre = ctrl;
      diff_1       = d1[NB-1:0];
      diff_2       = d2[NB-1:0];
      first_second = fs;
      ready        = (kind != 1);
      timeout      = (kind != 0);
      if (rel_reset) nReset = 1'b1;
      tick();
      ready        = 1'b0;
      timeout      = 1'b0;
      diff_1       = ~diff_1;
      diff_2       = ~diff_2;
      first_second = ~fs;
      model_event(kind, fs, d1, d2);
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (k < 3 && ctrl !== c_pre) held = 0;
         if (valid === 1'b1) begin
            nval++;
            pos  = k;
            c_at = ctrl;
            l_at = locked;
         end
      end
      check({tag, " ctrl_hold"}, held, 1);
      check({tag, " valid_count"}, nval, 1);
      check({tag, " valid_cycle"}, pos, 3);
      check({tag, " ctrl"}, c_at, m_ctrl);
      check({tag, " locked"}, l_at, m_locked);
   endtask

   initial begin
      int nval;
      logic [NB-1:0] c_at;
      #2;

      do_reset(1);
      run_event(0, 0, 20, 0, 0, "first_event");
      run_event(0, 0, 20, 0, 0, "repeat_event");

      do_reset(1);
      run_event(0, 0, 0, 20, 0, "negative_error");

      do_reset(1);
      run_event(1, 0, 0, 0, 0, "timeout_pos_clamp");
      do_reset(1);
      run_event(1, 1, 0, 0, 0, "timeout_neg_clamp");

      do_reset(1);
      for (int i = 0; i < 4; i++) run_event(0, 0, 1, 0, 0, "lock_build");
      check("lock_after_four", locked, 1);
      run_event(0, 0, 5, 0, 0, "lock_lost");

      do_reset(1);
      run_event(2, 1, 20, 0, 0, "both_edges_timeout_wins");

      do_reset(0);
      run_event(0, 0, 20, 0, 1, "ready_at_release");

      // Reset during ERR aborts the in-flight event.
      run_event(0, 0, 30, 0, 0, "pre_abort");
      diff_1 = 8'd20;
      diff_2 = 8'd0;
      ready  = 1'b1;
      tick();
      ready  = 1'b0;
      nReset = 1'b0;
      #1;
      check("abort_ctrl_async", ctrl, C_INIT);
      check("abort_locked", locked, 0);
      model_reset();
      tick();
      nReset = 1'b1;
      nval = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (valid === 1'b1) nval++;
      end
      check("abort_no_valid", nval, 0);
      check("abort_ctrl_hold", ctrl, C_INIT);

      // Second edge during INT must be ignored.
      diff_1 = 8'd20;
      diff_2 = 8'd0;
      ready  = 1'b1;
      tick();
      ready  = 1'b0;
      model_event(0, 0, 20, 0);
      tick();
      diff_1 = 8'd200;
      ready  = 1'b1;
      nval   = 0;
      c_at   = '0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (valid === 1'b1) begin
            nval++;
            c_at = ctrl;
         end
      end
      ready = 1'b0;
      check("drop_single_valid", nval, 1);
      check("drop_ctrl", c_at, m_ctrl);
      tick();
      run_event(0, 0, 3, 1, 0, "after_drop");

      do_reset(1);
      for (int i = 0; i < 40; i++) begin
         int sel;
         int gap;
         sel = $urandom_range(0, 9);
         gap = $urandom_range(0, 3);
         if (sel < 4)
            run_event(0, 0, $urandom_range(0, 4), $urandom_range(0, 4), 0, "rand_small");
         else if (sel < 7)
            run_event(0, 0, $urandom_range(0, C_MAX), $urandom_range(0, C_MAX), 0, "rand_big");
         else if (sel < 9)
            run_event(1, $urandom_range(0, 1), $urandom_range(0, C_MAX), 0, 0, "rand_timeout");
         else
            run_event(2, $urandom_range(0, 1), $urandom_range(0, C_MAX), 0, 0, "rand_both");
         for (int g = 0; g < gap; g++) tick();
      end

      // Drive the integrator into saturation, then back into the linear range.
      do_reset(1);
      for (int i = 0; i < 135; i++) run_event(1, 0, 0, 0, 0, "sat_up");
      for (int i = 0; i < 120; i++) run_event(1, 1, 0, 0, 0, "sat_down");
      run_event(0, 0, 10, 10, 0, "sat_recover");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/loop_filter.md
# loop_filter

Digital proportional-integral loop filter for the DPLL. Sits directly downstream of the phase-frequency detector: consumes each completed phase measurement (`diff_1`, `diff_2`, `first_second`, `ready`, `timeout`) and produces the registered control word that steers the DCO. It also reports lock status.

## Interface
- `KP_SHIFT`, default 1: proportional gain, applied as error >>> KP_SHIFT.
- `KI_SHIFT`, default 4: integral gain, applied as integrator >>> KI_SHIFT.
- `ACC_W`, default `N_BIT`+8: signed integrator width.
- `CTRL_INIT`, default 2**(`N_BIT`-1): control word at reset (DCO centre).
- `LOCK_TOL`, default 2: maximum |error| counted as in-lock.
- `LOCK_COUNT`, default 4: consecutive in-lock updates needed to assert `locked`.
- `Clock` in 1: system clock, all state on posedge.
- `nReset` in 1: reset, asynchronous, active-low.
- `ready` in 1: PFD measurement-complete level.
- `timeout` in 1: PFD timeout level.
- `first_second` in 1: 0 = f_1 led, 1 = f_2 led.
- `diff_1` in `N_BIT`: cycles f_1 was high alone.
- `diff_2` in `N_BIT`: cycles f_2 was high alone.
- `ctrl` out `N_BIT`: DCO control word, unsigned, registered.
- `valid` out 1: one-cycle pulse when `ctrl` is updated.
- `locked` out 1: lock indicator, registered.

## Operation
- Reset values: `ctrl`=CTRL_INIT, `valid`=0, `locked`=0, integrator=0, lock counter=0, state IDLE, `ready`/`timeout` edge registers=0.
- Trigger: rising edge of `ready` (measurement event) or rising edge of `timeout` (timeout event), detected against the previous-cycle registered copies. If both edges occur in the same cycle, the timeout event wins.
- Error e is signed and `N_BIT`+1 bits wide:
  - Measurement event: e = diff_1 − diff_2.
  - Timeout event: e = +(2**`N_BIT`−2) if first_second=0, otherwise −(2**`N_BIT`−2).
- FSM:
  - IDLE: on a trigger, latch e and the event type, then go to ERR.
  - ERR: integ ← sat(integ + e) to ±(2**(ACC_W−1)−1), then go to INT.
  - INT: sum = CTRL_INIT + (e >>> KP_SHIFT) + (integ >>> KI_SHIFT), computed at ACC_W+2 signed, then go to OUT.
  - OUT: `ctrl` ← clamp(sum, 0, 2**`N_BIT`−1), `valid`=1 for this cycle, update lock, then go to IDLE.
- Shifts are arithmetic and round toward −∞.
- Triggers that arrive while not in IDLE are dropped.
- Lock update, applied in OUT:
  - Timeout event: counter ← 0 and `locked` ← 0.
  - |e| ≤ LOCK_TOL: counter ← min(counter+1, LOCK_COUNT), and `locked` ← 1 when the new counter equals LOCK_COUNT.
  - Otherwise: counter ← 0 and `locked` ← 0.
- Reset asserted mid-operation immediately restores all reset values. No `valid` is produced for the in-flight event.

## Timing
- An edge seen at posedge t (the input is high at t, the registered copy is low) causes `valid` to be high during cycle t+3, with the new `ctrl` visible from that same edge.
- `ctrl` and `locked` change only in the `valid` cycle.
- Minimum spacing between accepted events is 4 cycles.
- `ready` high at reset release counts as an edge on the first clock.

## Structure
- `N_BIT` comes from the shared config.sv include.
- Move the FSM state enum (IDLE/ERR/INT/OUT) and the saturation-limit constant 2**`N_BIT`−2 into a shared `dpll_pkg`, so the PFD and the filter use the same limit.
- A sub-module `sat_add` (signed saturating adder, width-parameterised) is natural; use it for the integrator update.
- Everything else stays in one flat module.

## Test plan
All scenarios use `N_BIT`=8 and default parameters.
- Reset, then a `ready` pulse with diff_1=20, diff_2=0 → `valid` 3 cycles after the edge, `ctrl`=139 (128+10+1), `locked`=0.
- Repeat the identical event → integ=40, `ctrl`=140.
- From reset, diff_1=0, diff_2=20 → `ctrl`=116 (128−10−2, floor rounding).
- From reset, `timeout` rises with first_second=0 → e=+254, sum=270, `ctrl` clamps to 255, `locked`=0. With first_second=1 → `ctrl` clamps to 0.
- Four events with diff_1=1, diff_2=0 → `locked` rises in the fourth `valid` cycle. A fifth event with diff_1=5, diff_2=0 → `locked` falls.
- Assert `nReset` in the ERR cycle → `ctrl`=128 asynchronously and no `valid`. A second `ready` edge arriving during INT is dropped (exactly one `valid` pulse).
